// File: rtl/cnu_scheduler.sv
// Check-node phase sequencer for the LDPC decoder: issues check rows, tracks CNU latency,
// accumulates the syndrome and hands off to the variable-node phase until convergence or limit.
module cnu_scheduler #(
  parameter int NUM_CHECKS = 8,
  parameter int MAX_ITER   = 10,
  parameter int CNU_LAT    = 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic                            abort,
  input  logic                            stall,
  output logic                            row_valid,
  output logic [$clog2(NUM_CHECKS)-1:0]   row_addr,
  output logic                            wb_valid,
  output logic [$clog2(NUM_CHECKS)-1:0]   wb_addr,
  input  logic                            p_bit,
  output logic                            vnu_start,
  input  logic                            vnu_done,
  output logic                            busy,
  output logic                            done,
  output logic                            converged,
  output logic [$clog2(MAX_ITER+1)-1:0]   iter_count
);

  localparam int AW = $clog2(NUM_CHECKS);
  localparam int IW = $clog2(MAX_ITER + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_DRAIN, S_EVAL, S_VAR, S_DONE
  } state_t;

  state_t          state_q;
  logic [AW-1:0]   row_q;
  logic [IW-1:0]   iter_q;
  logic [IW-1:0]   iter_d;
  logic            synd_nz_q;
  logic            converged_q;
  logic            vnu_start_q;
  logic            done_q;
  logic [CNU_LAT-1:0] pipe_v_q;
  logic [CNU_LAT-1:0] pipe_v_d;
  logic [AW-1:0]   pipe_a_q [CNU_LAT];

  logic busy_w;
  logic abort_w;
  logic issue_w;
  logic last_row_w;

  assign busy_w     = (state_q != S_IDLE);
  assign abort_w    = abort && busy_w;
  // Abort wins over issue so nothing new enters the latency pipe on the abort cycle.
  assign issue_w    = (state_q == S_ISSUE) && !stall && !abort;
  assign last_row_w = (row_q == AW'(NUM_CHECKS - 1));
  assign iter_d     = iter_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      row_q       <= '0;
      iter_q      <= '0;
      synd_nz_q   <= 1'b0;
      converged_q <= 1'b0;
      vnu_start_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      vnu_start_q <= 1'b0;
      done_q      <= 1'b0;
      if (wb_valid && p_bit) synd_nz_q <= 1'b1;
      if (abort_w) begin
        state_q     <= S_IDLE;
        row_q       <= '0;
        converged_q <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: if (start) begin
            state_q     <= S_ISSUE;
            row_q       <= '0;
            iter_q      <= '0;
            converged_q <= 1'b0;
            synd_nz_q   <= 1'b0;
          end
          S_ISSUE: if (!stall) begin
            if (last_row_w) begin
              row_q   <= '0;
              state_q <= S_DRAIN;
            end else begin
              row_q <= row_q + 1'b1;
            end
          end
          S_DRAIN: if (pipe_v_q == '0) state_q <= S_EVAL;
          S_EVAL: begin
            iter_q <= iter_d;
            if (!synd_nz_q) begin
              state_q     <= S_DONE;
              converged_q <= 1'b1;
              done_q      <= 1'b1;
            end else if (iter_d == IW'(MAX_ITER)) begin
              state_q     <= S_DONE;
              converged_q <= 1'b0;
              done_q      <= 1'b1;
            end else begin
              state_q     <= S_VAR;
              vnu_start_q <= 1'b1;
            end
          end
          S_VAR: if (vnu_done) begin
            state_q   <= S_ISSUE;
            row_q     <= '0;
            synd_nz_q <= 1'b0;
          end
          S_DONE:  state_q <= S_IDLE;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  // Latency pipe runs every cycle; the CNU itself cannot be stalled.
  assign pipe_v_d[0] = issue_w;
  generate
    for (genvar gi = 1; gi < CNU_LAT; gi++) begin : g_pipe_v
      assign pipe_v_d[gi] = pipe_v_q[gi-1];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       pipe_v_q <= '0;
    else if (abort_w) pipe_v_q <= '0;
    else              pipe_v_q <= pipe_v_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pipe_a_q[0] <= '0;
    else        pipe_a_q[0] <= row_q;
  end

  generate
    for (genvar gi = 1; gi < CNU_LAT; gi++) begin : g_pipe_a
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pipe_a_q[gi] <= '0;
        else        pipe_a_q[gi] <= pipe_a_q[gi-1];
      end
    end
  endgenerate

  assign row_valid  = issue_w;
  assign row_addr   = row_q;
  assign wb_valid   = pipe_v_q[CNU_LAT-1];
  assign wb_addr    = pipe_a_q[CNU_LAT-1];
  assign vnu_start  = vnu_start_q;
  assign busy       = busy_w;
  assign done       = done_q;
  assign converged  = converged_q;
  assign iter_count = iter_q;

endmodule

// File: tb/tb_cnu_scheduler.sv
// Directed bench for cnu_scheduler (NUM_CHECKS=8, MAX_ITER=3, CNU_LAT=1): each scenario task
// drives one decode and compares the logged behaviour against hand-computed cycle numbers.
module tb_cnu_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       stall = 1'b0;
  logic       row_valid;
  logic [2:0] row_addr;
  logic       wb_valid;
  logic [2:0] wb_addr;
  logic       p_bit = 1'b0;
  logic       vnu_start;
  logic       vnu_done = 1'b0;
  logic       busy;
  logic       done;
  logic       converged;
  logic [1:0] iter_count;

  int n_cmp = 0;
  int n_fail = 0;

  cnu_scheduler #(.NUM_CHECKS(8), .MAX_ITER(3), .CNU_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .stall(stall),
    .row_valid(row_valid), .row_addr(row_addr), .wb_valid(wb_valid), .wb_addr(wb_addr),
    .p_bit(p_bit), .vnu_start(vnu_start), .vnu_done(vnu_done), .busy(busy), .done(done),
    .converged(converged), .iter_count(iter_count)
  );

  always #5 clk = ~clk;

  // Log of one decode run, filled by run_decode.
  int iss_row [64];
  int iss_cyc [64];
  int wb_row [64];
  int wb_cyc [64];
  int vnu_cyc [8];
  int n_iss, n_wb, n_vnu, n_done, n_stall_hold, n_wb_after_abort;
  int done_k, abort_k;
  int conv_at_done, iter_at_done, done_after, busy_after, conv_after;
  int busy_after_abort, iter_after_abort, conv_after_abort;

  task automatic run_decode(input int pb_row, input bit pb_all, input int vdelay,
                            input int stall_row, input int stall_len, input int start_again,
                            input int abort_mode, input int abort_cyc, input int budget);
    int  vd_timer = 0;
    int  st_cnt = 0;
    bit  st_armed = 0;
    n_iss = 0; n_wb = 0; n_vnu = 0; n_done = 0; n_stall_hold = 0; n_wb_after_abort = 0;
    done_k = -1; abort_k = -1;
    conv_at_done = -1; iter_at_done = -1; done_after = -1; busy_after = -1; conv_after = -1;
    busy_after_abort = -1; iter_after_abort = -1; conv_after_abort = -1;
    for (int k = 0; k < budget; k++) begin
      @(posedge clk); #1;
      start = (k == 0) || (k == start_again);
      vnu_done = 1'b0;
      if (vd_timer > 0) begin
        vd_timer--;
        if (vd_timer == 0) vnu_done = 1'b1;
      end
      stall = 1'b0;
      if (st_cnt > 0) begin
        stall = 1'b1;
        st_cnt--;
      end
      p_bit = wb_valid && (int'(wb_addr) == pb_row) && (pb_all || n_vnu == 0);
      abort = ((abort_mode == 1) && vnu_done) || ((abort_mode == 2) && (k == abort_cyc));
      if (abort) abort_k = k;
      @(negedge clk);
      if (row_valid && n_iss < 64) begin
        iss_row[n_iss] = int'(row_addr);
        iss_cyc[n_iss] = k;
        n_iss++;
        if (int'(row_addr) == stall_row && !st_armed) begin
          st_cnt = stall_len;
          st_armed = 1;
        end
      end
      if (stall && !row_valid && int'(row_addr) == stall_row + 1) n_stall_hold++;
      if (wb_valid && n_wb < 64) begin
        wb_row[n_wb] = int'(wb_addr);
        wb_cyc[n_wb] = k;
        n_wb++;
      end
      if (wb_valid && abort_k >= 0 && k > abort_k) n_wb_after_abort++;
      if (vnu_start && n_vnu < 8) begin
        vnu_cyc[n_vnu] = k;
        n_vnu++;
        vd_timer = vdelay;
      end
      if (done) begin
        n_done++;
        done_k = k;
        conv_at_done = int'(converged);
        iter_at_done = int'(iter_count);
      end
      if (abort_k >= 0 && k == abort_k + 1) begin
        busy_after_abort = int'(busy);
        iter_after_abort = int'(iter_count);
        conv_after_abort = int'(converged);
      end
      if (done_k >= 0 && k == done_k + 1) begin
        done_after = int'(done);
        busy_after = int'(busy);
        conv_after = int'(converged);
        break;
      end
      if (abort_k >= 0 && k == abort_k + 6) break;
    end
    @(posedge clk); #1;
    start = 0; abort = 0; stall = 0; vnu_done = 0; p_bit = 0;
  endtask

  function automatic int order_errors();
    int e = 0;
    for (int i = 0; i < n_iss; i++) if (iss_row[i] != i % 8) e++;
    return e;
  endfunction

  function automatic int latency_errors();
    int e = 0;
    int n = (n_iss < n_wb) ? n_iss : n_wb;
    for (int i = 0; i < n; i++)
      if (wb_cyc[i] != iss_cyc[i] + 1 || wb_row[i] != iss_row[i]) e++;
    return e;
  endfunction

  task automatic test_reset();
    logic [13:0] outs;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    outs = {row_valid, row_addr, wb_valid, wb_addr, vnu_start, busy, done, converged, iter_count};
    n_cmp++; if (outs !== 14'd0) begin n_fail++; $display("FAIL reset_outputs: got %h want 0", outs); end
    #1 rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle_busy: got %0b want 0", busy); end
    $display("test_reset done");
  endtask

  task automatic test_converge();
    run_decode(-1, 1, 4, -1, 0, -1, 0, 0, 100);
    n_cmp++; if (n_iss !== 8) begin n_fail++; $display("FAIL conv_issues: got %0d want 8", n_iss); end
    n_cmp++; if (order_errors() !== 0) begin n_fail++; $display("FAIL conv_order: got %0d errors want 0", order_errors()); end
    n_cmp++; if (iss_cyc[0] !== 1 || iss_cyc[7] !== 8) begin n_fail++; $display("FAIL conv_issue_cycles: got %0d..%0d want 1..8", iss_cyc[0], iss_cyc[7]); end
    n_cmp++; if (n_wb !== 8) begin n_fail++; $display("FAIL conv_wb_count: got %0d want 8", n_wb); end
    n_cmp++; if (latency_errors() !== 0) begin n_fail++; $display("FAIL conv_wb_latency: got %0d errors want 0", latency_errors()); end
    n_cmp++; if (n_vnu !== 0) begin n_fail++; $display("FAIL conv_vnu_start: got %0d want 0", n_vnu); end
    n_cmp++; if (n_done !== 1 || done_k !== 12) begin n_fail++; $display("FAIL conv_done: got count %0d at %0d want 1 at 12", n_done, done_k); end
    n_cmp++; if (conv_at_done !== 1 || iter_at_done !== 1) begin n_fail++; $display("FAIL conv_result: got conv %0d iter %0d want 1 1", conv_at_done, iter_at_done); end
    n_cmp++; if (done_after !== 0 || busy_after !== 0 || conv_after !== 1) begin n_fail++; $display("FAIL conv_after_done: got done %0d busy %0d conv %0d want 0 0 1", done_after, busy_after, conv_after); end
    $display("test_converge done: issues=%0d done_cycle=%0d", n_iss, done_k);
  endtask

  task automatic test_iter_limit();
    run_decode(5, 1, 4, -1, 0, -1, 0, 0, 200);
    n_cmp++; if (n_vnu !== 2) begin n_fail++; $display("FAIL lim_vnu_pulses: got %0d want 2", n_vnu); end
    n_cmp++; if (vnu_cyc[0] !== 12) begin n_fail++; $display("FAIL lim_vnu_cycle: got %0d want 12", vnu_cyc[0]); end
    n_cmp++; if (n_iss !== 24 || order_errors() !== 0) begin n_fail++; $display("FAIL lim_issues: got %0d (%0d order errors) want 24 (0)", n_iss, order_errors()); end
    n_cmp++; if (iss_cyc[8] !== 17) begin n_fail++; $display("FAIL lim_phase2_start: got %0d want 17", iss_cyc[8]); end
    n_cmp++; if (n_done !== 1 || done_k !== 44) begin n_fail++; $display("FAIL lim_done: got count %0d at %0d want 1 at 44", n_done, done_k); end
    n_cmp++; if (conv_at_done !== 0 || iter_at_done !== 3) begin n_fail++; $display("FAIL lim_result: got conv %0d iter %0d want 0 3", conv_at_done, iter_at_done); end
    $display("test_iter_limit done: vnu_starts=%0d issues=%0d", n_vnu, n_iss);
  endtask

  task automatic test_stall();
    run_decode(-1, 1, 4, 2, 3, -1, 0, 0, 100);
    n_cmp++; if (n_stall_hold !== 3) begin n_fail++; $display("FAIL stall_hold: got %0d want 3", n_stall_hold); end
    n_cmp++; if (n_iss !== 8 || order_errors() !== 0) begin n_fail++; $display("FAIL stall_rows: got %0d (%0d order errors) want 8 (0)", n_iss, order_errors()); end
    n_cmp++; if (iss_cyc[3] !== 7) begin n_fail++; $display("FAIL stall_resume: got %0d want 7", iss_cyc[3]); end
    n_cmp++; if (wb_cyc[2] !== 4 || latency_errors() !== 0) begin n_fail++; $display("FAIL stall_inflight_wb: got %0d (%0d errors) want 4 (0)", wb_cyc[2], latency_errors()); end
    n_cmp++; if (conv_at_done !== 1 || iter_at_done !== 1) begin n_fail++; $display("FAIL stall_result: got conv %0d iter %0d want 1 1", conv_at_done, iter_at_done); end
    $display("test_stall done: hold_cycles=%0d", n_stall_hold);
  endtask

  task automatic test_late_parity();
    run_decode(7, 0, 2, -1, 0, -1, 0, 0, 100);
    n_cmp++; if (n_vnu !== 1) begin n_fail++; $display("FAIL late_vnu_pulses: got %0d want 1", n_vnu); end
    n_cmp++; if (n_iss !== 16) begin n_fail++; $display("FAIL late_issues: got %0d want 16", n_iss); end
    n_cmp++; if (n_done !== 1 || conv_at_done !== 1 || iter_at_done !== 2) begin n_fail++; $display("FAIL late_result: got done %0d conv %0d iter %0d want 1 1 2", n_done, conv_at_done, iter_at_done); end
    $display("test_late_parity done: iter=%0d", iter_at_done);
  endtask

  task automatic test_abort_var();
    run_decode(0, 1, 3, -1, 0, 3, 1, 0, 100);
    n_cmp++; if (abort_k !== 15) begin n_fail++; $display("FAIL abort_var_cycle: got %0d want 15", abort_k); end
    n_cmp++; if (busy_after_abort !== 0) begin n_fail++; $display("FAIL abort_var_idle: got busy %0d want 0", busy_after_abort); end
    n_cmp++; if (n_done !== 0) begin n_fail++; $display("FAIL abort_var_done: got %0d want 0", n_done); end
    n_cmp++; if (iter_after_abort !== 1 || conv_after_abort !== 0) begin n_fail++; $display("FAIL abort_var_hold: got iter %0d conv %0d want 1 0", iter_after_abort, conv_after_abort); end
    n_cmp++; if (n_iss !== 8 || order_errors() !== 0 || iss_cyc[7] !== 8) begin n_fail++; $display("FAIL abort_start_ignored: got %0d issues last at %0d want 8 at 8", n_iss, iss_cyc[7]); end
    n_cmp++; if (n_wb_after_abort !== 0) begin n_fail++; $display("FAIL abort_var_wb: got %0d want 0", n_wb_after_abort); end
    $display("test_abort_var done: abort_cycle=%0d", abort_k);
  endtask

  task automatic test_abort_issue();
    run_decode(-1, 1, 4, -1, 0, -1, 2, 4, 100);
    n_cmp++; if (n_iss !== 3) begin n_fail++; $display("FAIL abort_iss_issues: got %0d want 3", n_iss); end
    n_cmp++; if (busy_after_abort !== 0 || n_wb_after_abort !== 0 || n_done !== 0) begin n_fail++; $display("FAIL abort_iss_flush: got busy %0d wb %0d done %0d want 0 0 0", busy_after_abort, n_wb_after_abort, n_done); end
    $display("test_abort_issue done: issues=%0d", n_iss);
  endtask

  task automatic test_reset_mid();
    logic [13:0] outs;
    int found = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (row_valid && row_addr == 3'd4) begin found = 1; break; end
      @(posedge clk); #1;
    end
    n_cmp++; if (found !== 1) begin n_fail++; $display("FAIL rst_mid_reach_row4: got %0d want 1", found); end
    #2 rst_n = 1'b0;
    #1 outs = {row_valid, row_addr, wb_valid, wb_addr, vnu_start, busy, done, converged, iter_count};
    n_cmp++; if (outs !== 14'd0) begin n_fail++; $display("FAIL rst_mid_outputs: got %h want 0", outs); end
    @(posedge clk); #1 rst_n = 1'b1;
    run_decode(-1, 1, 4, -1, 0, -1, 0, 0, 100);
    n_cmp++; if (iss_row[0] !== 0 || n_iss !== 8 || conv_at_done !== 1) begin n_fail++; $display("FAIL rst_mid_restart: got row %0d issues %0d conv %0d want 0 8 1", iss_row[0], n_iss, conv_at_done); end
    $display("test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_converge();
    test_iter_limit();
    test_stall();
    test_late_parity();
    test_abort_var();
    test_abort_issue();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/cnu_scheduler.md
Name: cnu_scheduler

Overview:
- Sequences the check-node phase of the LDPC decoder. It issues one check row per cycle to the CNU input mux and memory, and tracks the CNU pipeline latency so write-back and parity are qualified correctly.
- It alternates check phases with variable-node phases through a start/done handshake.
- It stops on syndrome convergence, when all CNU parity bits are zero in one check phase, or when the iteration limit is reached.

Parameters:
- NUM_CHECKS, 8, number of check rows processed per check phase (min 2).
- MAX_ITER, 10, maximum decoding iterations (min 1).
- CNU_LAT, 1, cycles from CNU input sampling to valid Y/p_bit (min 1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin decode; honoured only in IDLE.
- abort  in  1  synchronous abort; returns to IDLE without done.
- stall  in  1  message memory not ready; suppresses issue this cycle.
- row_valid  out  1  row_addr valid; CNU X inputs must be driven this cycle.
- row_addr  out  $clog2(NUM_CHECKS)  check row being issued.
- wb_valid  out  1  CNU Y outputs valid for write-back.
- wb_addr  out  $clog2(NUM_CHECKS)  row of current CNU outputs.
- p_bit  in  1  CNU parity output, sampled only when wb_valid=1.
- vnu_start  out  1  one-cycle pulse launching the variable-node phase.
- vnu_done  in  1  variable-node phase complete; sampled only in VAR.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at decode end.
- converged  out  1  final syndrome was zero; valid from the done pulse until next start.
- iter_count  out  $clog2(MAX_ITER+1)  iterations executed.

Behaviour:
- Reset (async, rst_n=0): state IDLE. All outputs 0, including row_addr, wb_addr, iter_count and converged. Pipeline valid bits cleared, syndrome flag cleared.
- States: IDLE, ISSUE, DRAIN, EVAL, VAR, DONE.
- IDLE:
  - start=1 moves to ISSUE with row=0, iter_count=0, converged=0, synd_nz=0.
  - start while busy is ignored.
- ISSUE:
  - stall=0: row_valid=1, row_addr=row, row increments.
  - Issuing row NUM_CHECKS-1 moves to DRAIN next cycle.
  - stall=1: row_valid=0, row_addr holds.
  - No wrap within a phase: exactly NUM_CHECKS issues per phase.
- Latency pipeline:
  - wb_valid and wb_addr are row_valid and row_addr delayed by exactly CNU_LAT cycles, via a shift register that runs every cycle (the CNU has no enable).
  - Stall does not freeze in-flight entries.
  - When wb_valid=1, synd_nz <= synd_nz | p_bit.
- DRAIN: remains until all pipeline valid bits are 0, then moves to EVAL. The last wb_valid's p_bit is therefore included in EVAL.
- EVAL (1 cycle): iter_count increments.
  - If synd_nz=0: DONE with converged=1.
  - Else if the new iter_count == MAX_ITER: DONE with converged=0.
  - Else: VAR, pulsing vnu_start on entry.
- VAR: waits for vnu_done=1, then returns to ISSUE with row=0 and synd_nz=0. vnu_start is never reasserted while in VAR.
- DONE (1 cycle): done=1, then IDLE. converged and iter_count hold until the next accepted start.
- abort=1 in any busy state:
  - Next state IDLE, done stays 0.
  - Pipeline valid bits flushed, so no wb_valid after abort.
  - iter_count holds its value; converged=0.
  - abort has priority over start, stall and vnu_done in the same cycle.
- vnu_done outside VAR is ignored. stall outside ISSUE is ignored.
- rst_n asserted mid-decode forces reset values immediately. No done pulse occurs.

Test Plan:
- Convergence, first iteration: NUM_CHECKS=8, CNU_LAT=1, start with p_bit=0 always. Expect row_valid on 8 consecutive cycles (rows 0..7), wb_valid rows 0..7 one cycle later, no vnu_start, done with converged=1 and iter_count=1.
- Iteration limit: MAX_ITER=3, p_bit=1 on row 5 every phase, vnu_done 4 cycles after each vnu_start. Expect exactly 2 vnu_start pulses and 24 issues, then done with converged=0 and iter_count=3.
- Stall: stall high for 3 cycles after row 2 issues. Expect row_addr held at 3 with row_valid=0 during the stall, no skipped or duplicated rows. In-flight row 2 still produces wb_valid one cycle after its issue.
- Late parity: p_bit=1 only on the wb_valid for row 7 in iteration 1, zero after. Expect DRAIN to capture it, one vnu_start, then converged=1 with iter_count=2.
- Abort and start collision: assert abort together with vnu_done in VAR. Expect IDLE next cycle, no done, no further wb_valid. start asserted during ISSUE is ignored.
- Reset mid-decode: drop rst_n while in ISSUE at row 4. Expect all outputs 0 asynchronously. After release, a new start begins issuing from row 0.
